fmac_operand_feeder: RTL and testbench

//  Drives the fmac operand inputs. Buffers {x,y} pairs from an upstream valid/ready source in a FIFO.

---
 rtl/fmac_operand_feeder.sv | 210 +++++++++++++++++++++
 tb/tb_fmac_operand_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fmac_operand_feeder.sv
// fmac_operand_feeder
//   Feeds {x,y} operand pairs into an fmac. Pairs arrive on a valid/ready
//   interface and are buffered in a FIFO. Each pair is held on x/y for
//   HOLD_CYCLES cycles and is followed by one 0/0 gap cycle. The fmac
//   accumulates whenever its operands change, so the gap makes two identical
//   consecutive pairs register as two separate products.
//   The block also watches the fmac result 'a' and counts threshold trips.
//   A trip is the fmac clearing 'a' to 0 on the cycle after 'a' was above
//   the threshold.
//
// Parameters
//   DEPTH        FIFO entries (power of 2, >= 2)
//   HOLD_CYCLES  cycles each pair is held on x/y before the gap (>= 1)
//   TRIP_W       width of the saturating trip counter
//
// Ports
//   CLK, RESET         clock; synchronous active-low reset
//   in_valid/in_ready  upstream handshake; in_ready = FIFO not full
//   in_x, in_y         upstream operand pair
//   run                level; 1 = drain the FIFO into the fmac
//   x, y               registered fmac operands
//   a, threshold       fmac result and the threshold wired to the fmac
//   busy               FSM not idle
//   trip               one-cycle pulse per detected threshold trip
//   trip_count         saturating trip counter
//   pair_count         (FEEDER_STATS_EN only) pops so far, wraps at 16 bits
//   fifo_level         (FEEDER_STATS_EN only) current FIFO occupancy
//
// Optional feature macro: FEEDER_STATS_EN
module fmac_operand_feeder #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 1,
  parameter int TRIP_W      = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_x,
  input  logic [7:0]        in_y,
  input  logic              run,
  output logic [7:0]        x,
  output logic [7:0]        y,
  input  logic [15:0]       a,
  input  logic [15:0]       threshold,
  output logic              busy,
  output logic              trip,
  output logic [TRIP_W-1:0] trip_count
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]              pair_count,
  output logic [$clog2(DEPTH):0]   fifo_level
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  // FIFO storage and pointers
  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  logic          full, empty, push, pop;
  logic [15:0]   head;

  // FSM and operand registers
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q,  hold_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic          busy_q, busy_d;

  // Trip detection
  logic [15:0]       a_q;
  logic              trip_q, trip_d;
  logic [TRIP_W-1:0] trip_count_q, trip_count_d;

`ifdef FEEDER_STATS_EN
  logic [15:0] pair_count_q, pair_count_d;
`endif

  always_comb begin
    full  = (count_q == (PW+1)'(DEPTH));
    empty = (count_q == '0);
    push  = in_valid && !full;
    head  = mem_q[rd_ptr_q];
  end

  // FSM next state. Popping happens only from IDLE or GAP, so a pair
  // already on x/y always finishes its hold and its gap cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    x_d     = x_q;
    y_d     = y_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        x_d     = '0;
        y_d     = '0;
        state_d = IDLE;
        if (run && !empty) begin
          pop     = 1'b1;
          x_d     = head[15:8];
          y_d     = head[7:0];
          hold_d  = HW'(HOLD_CYCLES);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_q == HW'(1)) begin
          x_d     = '0;
          y_d     = '0;
          state_d = GAP;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: begin
        x_d     = '0;
        y_d     = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FIFO pointer and occupancy bookkeeping; DEPTH is a power of two, so
  // the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // A trip is a above threshold on the previous cycle followed by a == 0
  always_comb begin
    trip_d       = (a_q > threshold) && (a == '0);
    trip_count_d = trip_count_q;
    if (trip_d && (trip_count_q != '1)) trip_count_d = trip_count_q + TRIP_W'(1);
  end

`ifdef FEEDER_STATS_EN
  always_comb begin
    pair_count_d = pair_count_q;
    if (pop) pair_count_d = pair_count_q + 16'd1;
  end
`endif

  // FIFO data is not reset; only the pointers and the count define validity
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y};
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      hold_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      busy_q       <= 1'b0;
      a_q          <= '0;
      trip_q       <= 1'b0;
      trip_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      x_q          <= x_d;
      y_q          <= y_d;
      busy_q       <= busy_d;
      a_q          <= a;
      trip_q       <= trip_d;
      trip_count_q <= trip_count_d;
    end
  end

`ifdef FEEDER_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RESET) pair_count_q <= '0;
    else        pair_count_q <= pair_count_d;
  end

  assign pair_count = pair_count_q;
  assign fifo_level = count_q;
`endif

  assign in_ready   = !full;
  assign x          = x_q;
  assign y          = y_q;
  assign busy       = busy_q;
  assign trip       = trip_q;
  assign trip_count = trip_count_q;

endmodule

// File: tb/tb_fmac_operand_feeder.sv
// Directed bench for fmac_operand_feeder. A small behavioural fmac drives
// 'a': it adds x*y whenever the operand pair changes and clears itself the
// cycle after its value exceeds the threshold.
module tb_fmac_operand_feeder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x, in_y;
  logic        run;
  logic [7:0]  x, y;
  logic [15:0] a;
  logic [15:0] threshold;
  logic        busy;
  logic        trip;
  logic [7:0]  trip_count;
`ifdef FEEDER_STATS_EN
  logic [15:0] pair_count;
  logic [3:0]  fifo_level;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  fmac_operand_feeder #(.DEPTH(8), .HOLD_CYCLES(1), .TRIP_W(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .run        (run),
    .x          (x),
    .y          (y),
    .a          (a),
    .threshold  (threshold),
    .busy       (busy),
    .trip       (trip),
    .trip_count (trip_count)
`ifdef FEEDER_STATS_EN
    ,
    .pair_count (pair_count),
    .fifo_level (fifo_level)
`endif
  );

  // Behavioural fmac
  logic [15:0] acc;
  logic [15:0] prev;
  logic        fm_clr;
  always @(posedge CLK) begin
    if (!RESET || fm_clr) begin
      acc  <= '0;
      prev <= '0;
    end else begin
      if (acc > threshold)        acc <= '0;
      else if ({x, y} != prev)    acc <= acc + x * y;
      prev <= {x, y};
    end
  end
  assign a = acc;

  // Trip pulse counter and peak-a monitor, sampled mid-cycle
  int          trip_seen;
  logic [15:0] max_a;
  logic        mon_clr;
  always @(negedge CLK) begin
    if (mon_clr) begin
      trip_seen <= 0;
      max_a     <= '0;
    end else begin
      if (trip === 1'b1) trip_seen <= trip_seen + 1;
      if (a > max_a)     max_a <= a;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] px, input logic [7:0] py);
    in_valid = 1'b1;
    in_x     = px;
    in_y     = py;
    step();
    in_valid = 1'b0;
  endtask

  logic [7:0] exp_x [5];
  logic [7:0] exp_y [5];
  logic       exp_b [5];
  logic [7:0] got_x [16];
  logic [7:0] got_y [16];
  int         n_got, last_c, idle_c, pushed, bad;

  initial begin
    RESET = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; run = 1'b0;
    threshold = 16'hFFFF; fm_clr = 1'b0; mon_clr = 1'b1;

    // 1: reset
    step();
    RESET = 1'b1;
    mon_clr = 1'b0;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    check("rst_trip_count", trip_count, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef FEEDER_STATS_EN
    check("rst_pair_count", pair_count, 0);
    check("rst_fifo_level", fifo_level, 0);
`endif

    // 2: two identical pairs, each followed by a gap
    push(8'd3, 8'd4);
    push(8'd3, 8'd4);
    check("t2_idle_before_run", busy, 0);
    run = 1'b1;
    exp_x = '{8'd3, 8'd0, 8'd3, 8'd0, 8'd0};
    exp_y = '{8'd4, 8'd0, 8'd4, 8'd0, 8'd0};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t2_x[%0d]", i), x, exp_x[i]);
      check($sformatf("t2_y[%0d]", i), y, exp_y[i]);
      check($sformatf("t2_busy[%0d]", i), busy, exp_b[i]);
    end
    step(); step();
    check("t2_fmac_a", a, 24);
    run = 1'b0;

    // 3: fill FIFO, ninth push ignored, drain in order
    for (int i = 1; i <= 8; i++) push(8'(i), 8'd1);
    check("t3_full_in_ready", in_ready, 0);
`ifdef FEEDER_STATS_EN
    check("t3_level_full", fifo_level, 8);
`endif
    push(8'd9, 8'd9);
    check("t3_still_full", in_ready, 0);
    run = 1'b1;
    n_got = 0; last_c = -1; idle_c = -1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (x != 0) begin
        if (n_got < 16) begin got_x[n_got] = x; got_y[n_got] = y; end
        n_got++;
        last_c = c;
      end
      if (!busy && n_got > 0) begin idle_c = c; break; end
    end
    check("t3_pairs_drained", n_got, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_x[%0d]", i), got_x[i], i + 1);
      check($sformatf("t3_y[%0d]", i), got_y[i], 1);
    end
    check("t3_busy_fall_delay", idle_c - last_c, 2);
    run = 1'b0;

    // 4: threshold trips
    threshold = 16'd100;
    fm_clr = 1'b1; mon_clr = 1'b1;
    step();
    fm_clr = 1'b0; mon_clr = 1'b0;
    push(8'd10, 8'd11);
    run = 1'b1;
    repeat (10) step();
    check("t4_trip_pulses", trip_seen, 1);
    check("t4_trip_count", trip_count, 1);
    check("t4_peak_a", max_a, 110);
    check("t4_a_cleared", a, 0);
    pushed = 0;
    in_x = 8'd10; in_y = 8'd11;
    for (int c = 0; c < 3000 && pushed < 299; c++) begin
      in_valid = 1'b1;
      if (in_ready) pushed++;
      step();
    end
    in_valid = 1'b0;
    check("t4_pushed", pushed, 299);
    for (int c = 0; c < 100 && busy; c++) step();
    check("t4_drain_done", busy, 0);
    repeat (5) step();
    check("t4_trip_pulses_300", trip_seen, 300);
    check("t4_trip_count_sat", trip_count, 255);
    run = 1'b0;

    // 5: reset during DRIVE with pairs queued
    threshold = 16'hFFFF;
    push(8'd5, 8'd6);
    push(8'd7, 8'd8);
    push(8'd9, 8'd10);
    run = 1'b1;
    step();
    check("t5_drive_x", x, 5);
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    check("t5_x", x, 0);
    check("t5_y", y, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_trip_count", trip_count, 0);
`ifdef FEEDER_STATS_EN
    check("t5_fifo_level", fifo_level, 0);
`endif
    bad = 0;
    repeat (8) begin
      step();
      if (x != 0 || busy) bad = 1;
    end
    check("t5_no_pop_after_release", bad, 0);
    run = 1'b0;

    // 6: five pairs drained
    for (int i = 1; i <= 5; i++) push(8'(10 + i), 8'd2);
    run = 1'b1;
    n_got = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (x != 0) begin
        if (n_got < 16) got_x[n_got] = x;
        n_got++;
      end
      if (!busy && n_got > 0) break;
    end
    check("t6_pairs_drained", n_got, 5);
    check("t6_last_x", got_x[4], 15);
`ifdef FEEDER_STATS_EN
    check("t6_pair_count", pair_count, 5);
    check("t6_fifo_level", fifo_level, 0);
`endif
    run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
